// File: rtl/clock_rate_meter.sv
// Measures the period of a slow asynchronous square wave in clk cycles.
// Reports MAX_SPEED / period through a one-bit-per-cycle restoring divider.
module clock_rate_meter #(
  parameter int MAX_SPEED   = 50000000,
  parameter int CNT_W       = 26,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] speed_out,
  output logic             valid,
  output logic             busy,
  output logic             stalled,
  output logic             overrun
);

  // state   | meaning
  // ARM     | waiting for the first rising edge, no period counted yet
  // MEASURE | counter running since the last edge, waiting for the next one
  // DIVIDE  | computing MAX_SPEED / period_out, one quotient bit per cycle
  typedef enum logic [1:0] {ARM, MEASURE, DIVIDE} state_t;

  localparam int BIT_W = $clog2(CNT_W);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_SPEED);

  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  logic rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] divisor;
  logic [CNT_W-1:0] quo;
  logic [CNT_W-1:0] rem;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W:0] rem_sh;
  logic [CNT_W:0] rem_sub;
  logic [CNT_W-1:0] quo_nxt;
  logic [CNT_W-1:0] rem_nxt;

  assign rise = sync[SYNC_STAGES-1] & ~hist;

  // quo starts as the dividend and is shifted out MSB-first while quotient bits shift in
  always_comb begin
    rem_sh  = {rem, quo[CNT_W-1]};
    rem_sub = rem_sh - {1'b0, divisor};
    quo_nxt = {quo[CNT_W-2:0], ~rem_sub[CNT_W]};
    rem_nxt = rem_sub[CNT_W] ? rem_sh[CNT_W-1:0] : rem_sub[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARM;
      sync       <= '0;
      hist       <= 1'b0;
      cnt        <= '0;
      divisor    <= '0;
      quo        <= '0;
      rem        <= '0;
      bit_cnt    <= '0;
      period_out <= '0;
      speed_out  <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      stalled    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], sig_in};
      hist  <= sync[SYNC_STAGES-1];
      valid <= 1'b0;

      if (rise)
        cnt <= CNT_W'(1);
      else if (cnt != MAX_V)
        cnt <= cnt + 1'b1;

      case (state)
        ARM: begin
          if (rise)
            state <= MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            period_out <= cnt;
            divisor    <= cnt;
            quo        <= MAX_V;
            rem        <= '0;
            bit_cnt    <= BIT_W'(CNT_W - 1);
            busy       <= 1'b1;
            state      <= DIVIDE;
          end else if (cnt == MAX_V) begin
            stalled    <= 1'b1;
            speed_out  <= '0;
            period_out <= '0;
            state      <= ARM;
          end
        end
        DIVIDE: begin
          quo     <= quo_nxt;
          rem     <= rem_nxt;
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == '0) begin
            // an edge landing on the final step is the start of the next period, not an overrun
            speed_out <= quo_nxt;
            valid     <= 1'b1;
            stalled   <= 1'b0;
            busy      <= 1'b0;
            state     <= MEASURE;
          end else if (rise) begin
            overrun <= 1'b1;
          end
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule
